// File: rtl/rd_slot_alloc.sv
// Read-side slot allocator: tracks outstanding AR transactions in a slot table
// with one linked list per AXI ID, and feeds counter next-values downstream.
module rd_slot_alloc #(
  parameter  int NumSlots = 8,
  parameter  int IdWidth  = 2,
  parameter  int CntWidth = 10,
  localparam int SlotW    = $clog2(NumSlots),
  localparam int NumIds   = 2**IdWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         ar_valid_i,
  input  logic                         ar_ready_i,
  input  logic [IdWidth-1:0]           ar_id_i,
  input  logic [7:0]                   ar_len_i,
  input  logic                         r_valid_i,
  input  logic                         r_ready_i,
  input  logic                         r_last_i,
  input  logic [IdWidth-1:0]           r_id_i,
  input  logic [CntWidth-1:0]          budget_i,
  input  logic [NumSlots*CntWidth-1:0] cnt_q_i,
  output logic [NumSlots-1:0]          slot_free_o,
  output logic [NumSlots*IdWidth-1:0]  slot_id_o,
  output logic [NumSlots*SlotW-1:0]    slot_next_o,
  output logic [NumSlots*CntWidth-1:0] slot_cnt_d_o,
  output logic [NumIds*SlotW-1:0]      head_o,
  output logic [NumIds-1:0]            head_vld_o,
  output logic                         full_o,
  output logic                         err_ovf_o,
  output logic                         err_unexp_o
);

  // Wide enough that budget + 255 + 1 can never wrap before saturation.
  localparam int SumW = ((CntWidth > 8) ? CntWidth : 8) + 1;

  logic [NumSlots-1:0] free_q, free_d;
  logic [IdWidth-1:0]  id_q   [NumSlots];
  logic [IdWidth-1:0]  id_d   [NumSlots];
  logic [SlotW-1:0]    next_q [NumSlots];
  logic [SlotW-1:0]    next_d [NumSlots];
  logic [SlotW-1:0]    head_q [NumIds];
  logic [SlotW-1:0]    head_d [NumIds];
  logic [SlotW-1:0]    tail_q [NumIds];
  logic [SlotW-1:0]    tail_d [NumIds];
  logic [NumIds-1:0]   hvld_q, hvld_d;
  logic                ovf_q, unexp_q;

  logic                full;
  logic                ar_hs, alloc, rel_req, rel;
  logic [SlotW-1:0]    alloc_slot, rel_slot;
  logic [CntWidth-1:0] new_cnt;

  function automatic logic [CntWidth-1:0] sat_cnt(input logic [SumW-1:0] sum);
    if (sum > SumW'({CntWidth{1'b1}})) begin
      return '1;
    end
    return sum[CntWidth-1:0];
  endfunction

  assign full     = ~|free_q;
  assign ar_hs    = ar_valid_i & ar_ready_i;
  assign alloc    = ar_hs & ~full;
  assign rel_req  = r_valid_i & r_ready_i & r_last_i;
  assign rel      = rel_req & hvld_q[r_id_i];
  assign rel_slot = head_q[r_id_i];
  assign new_cnt  = sat_cnt(SumW'(budget_i) + SumW'(ar_len_i) + SumW'(1));

  // Lowest-index free slot from registered state, so a slot freed this cycle is not reused yet.
  always_comb begin
    alloc_slot = '0;
    for (int k = NumSlots - 1; k >= 0; k--) begin
      if (free_q[k]) alloc_slot = SlotW'(k);
    end
  end

  // Release is applied first so a same-ID allocation sees the post-release list.
  always_comb begin
    free_d = free_q;
    id_d   = id_q;
    next_d = next_q;
    head_d = head_q;
    tail_d = tail_q;
    hvld_d = hvld_q;
    if (rel) begin
      free_d[rel_slot] = 1'b1;
      if (rel_slot == tail_q[r_id_i]) hvld_d[r_id_i] = 1'b0;
      else                            head_d[r_id_i] = next_q[rel_slot];
    end
    if (alloc) begin
      free_d[alloc_slot] = 1'b0;
      id_d[alloc_slot]   = ar_id_i;
      next_d[alloc_slot] = alloc_slot;
      if (hvld_d[ar_id_i]) begin
        next_d[tail_q[ar_id_i]] = alloc_slot;
        tail_d[ar_id_i]         = alloc_slot;
      end else begin
        head_d[ar_id_i] = alloc_slot;
        tail_d[ar_id_i] = alloc_slot;
        hvld_d[ar_id_i] = 1'b1;
      end
    end
  end

  always_comb begin
    slot_cnt_d_o = cnt_q_i;
    for (int k = 0; k < NumSlots; k++) begin
      if (alloc && (alloc_slot == SlotW'(k))) slot_cnt_d_o[k*CntWidth +: CntWidth] = new_cnt;
    end
  end

  // Table register stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_q  <= '1;
      hvld_q  <= '0;
      ovf_q   <= 1'b0;
      unexp_q <= 1'b0;
      for (int k = 0; k < NumSlots; k++) begin
        id_q[k]   <= '0;
        next_q[k] <= '0;
      end
      for (int i = 0; i < NumIds; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
      end
    end else begin
      free_q  <= free_d;
      id_q    <= id_d;
      next_q  <= next_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      hvld_q  <= hvld_d;
      ovf_q   <= ar_hs & full;
      unexp_q <= rel_req & ~hvld_q[r_id_i];
    end
  end

  for (genvar g = 0; g < NumSlots; g++) begin : g_slot
    assign slot_id_o[g*IdWidth +: IdWidth] = id_q[g];
    assign slot_next_o[g*SlotW +: SlotW]   = next_q[g];
  end

  for (genvar g = 0; g < NumIds; g++) begin : g_id
    assign head_o[g*SlotW +: SlotW] = head_q[g];
  end

  assign slot_free_o = free_q;
  assign head_vld_o  = hvld_q;
  assign full_o      = full;
  assign err_ovf_o   = ovf_q;
  assign err_unexp_o = unexp_q;

endmodule
